res_mem_arbiter: RTL and testbench

RES_MEM_ARBITER -- requirements
Module: res_mem_arbiter

---
 rtl/res_mem_arbiter.sv | 116 +++++++++++
 tb/tb_res_mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/res_mem_arbiter.sv
// Round-robin arbiter serializing one writer and one reader onto a single-port result memory.
// Optional build macro RES_ARB_UNSWAP_EN: undo the memory's byte reversal on read capture.
module res_mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrReq,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrGnt,
    input  logic              rdReq,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    output logic              memREn,
    output logic              memWEn,
    output logic [31:0]       memAddr,
    output logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] memDataOut
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
    typedef enum logic {GNT_WR, GNT_RD} gnt_t;

    state_t            state_q;
    gnt_t              lastGnt_q;
    logic              wrGnt_q;
    logic              rdValid_q;
    logic [DATA_W-1:0] rdData_q;
    logic              memREn_q;
    logic              memWEn_q;
    logic [31:0]       memAddr_q;
    logic [DATA_W-1:0] memDataIn_q;

    logic              pick_wr_d;
    logic              pick_rd_d;
    logic [DATA_W-1:0] capture_d;

    // On a tie the side not granted last wins.
    always_comb begin
        pick_wr_d = wrReq && (!rdReq || (lastGnt_q == GNT_RD));
        pick_rd_d = rdReq && !pick_wr_d;
    end

    always_comb begin
        capture_d = memDataOut;
`ifdef RES_ARB_UNSWAP_EN
        for (int unsigned b = 0; b < DATA_W / 8; b++) begin
            capture_d[8*b +: 8] = memDataOut[(DATA_W - 8 - 8*b) +: 8];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGnt_q   <= GNT_RD;
            wrGnt_q     <= 1'b0;
            rdValid_q   <= 1'b0;
            rdData_q    <= '0;
            memREn_q    <= 1'b0;
            memWEn_q    <= 1'b0;
            memAddr_q   <= '0;
            memDataIn_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Memory-side outputs are loaded here so they are valid for the whole access cycle.
                    if (pick_wr_d) begin
                        state_q     <= WRITE;
                        lastGnt_q   <= GNT_WR;
                        wrGnt_q     <= 1'b1;
                        memWEn_q    <= 1'b1;
                        memAddr_q   <= 32'(wrAddr);
                        memDataIn_q <= wrData;
                    end else if (pick_rd_d) begin
                        state_q   <= READ;
                        lastGnt_q <= GNT_RD;
                        memREn_q  <= 1'b1;
                        memAddr_q <= 32'(rdAddr);
                    end
                end
                WRITE: begin
                    state_q     <= IDLE;
                    wrGnt_q     <= 1'b0;
                    memWEn_q    <= 1'b0;
                    memAddr_q   <= '0;
                    memDataIn_q <= '0;
                end
                READ: begin
                    state_q   <= RESP;
                    rdData_q  <= capture_d;
                    rdValid_q <= 1'b1;
                    memREn_q  <= 1'b0;
                    memAddr_q <= '0;
                end
                RESP: begin
                    state_q   <= IDLE;
                    rdValid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wrGnt     = wrGnt_q;
    assign rdValid   = rdValid_q;
    assign rdData    = rdData_q;
    assign memREn    = memREn_q;
    assign memWEn    = memWEn_q;
    assign memAddr   = memAddr_q;
    assign memDataIn = memDataIn_q;

endmodule

// File: tb/tb_res_mem_arbiter.sv
// Directed bench for res_mem_arbiter with a byte-reversing 128-word memory alongside.
module tb_res_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrReq, rdReq;
    logic [6:0]  wrAddr, rdAddr;
    logic [31:0] wrData;
    logic        wrGnt, rdValid;
    logic [31:0] rdData;
    logic        memREn, memWEn;
    logic [31:0] memAddr, memDataIn, memDataOut;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [128];

    always #5 clk = ~clk;

    res_mem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .wrReq(wrReq), .wrAddr(wrAddr), .wrData(wrData), .wrGnt(wrGnt),
        .rdReq(rdReq), .rdAddr(rdAddr), .rdValid(rdValid), .rdData(rdData),
        .memREn(memREn), .memWEn(memWEn), .memAddr(memAddr),
        .memDataIn(memDataIn), .memDataOut(memDataOut)
    );

    // Memory stores as written and returns data byte-reversed, combinationally.
    always @(posedge clk) if (memWEn) mem[memAddr[6:0]] <= memDataIn;
    always_comb begin
        logic [31:0] w;
        w = mem[memAddr[6:0]];
        memDataOut = {w[7:0], w[15:8], w[23:16], w[31:24]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " wrGnt"}, {31'b0, wrGnt}, 32'd0);
        chk({tag, " rdValid"}, {31'b0, rdValid}, 32'd0);
        chk({tag, " memWEn"}, {31'b0, memWEn}, 32'd0);
        chk({tag, " memREn"}, {31'b0, memREn}, 32'd0);
        chk({tag, " memAddr"}, memAddr, 32'd0);
        chk({tag, " memDataIn"}, memDataIn, 32'd0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_raw;
        logic [31:0] exp_unswap;
    } vec_t;

    vec_t vecs [9];

    task automatic do_write(input logic [6:0] a, input logic [31:0] d);
        @(negedge clk);
        wrReq = 1'b1; wrAddr = a; wrData = d;
        @(posedge clk); #1;
        chk("wr wrGnt", {31'b0, wrGnt}, 32'd1);
        chk("wr memWEn", {31'b0, memWEn}, 32'd1);
        chk("wr memREn", {31'b0, memREn}, 32'd0);
        chk("wr memAddr", memAddr, {25'b0, a});
        chk("wr memDataIn", memDataIn, d);
        @(negedge clk);
        wrReq = 1'b0;
        @(posedge clk); #1;
        chk_quiet("wr-after");
    endtask

    task automatic do_read(input logic [6:0] a, input logic [31:0] exp);
        @(negedge clk);
        rdReq = 1'b1; rdAddr = a;
        @(posedge clk); #1;
        chk("rd memREn", {31'b0, memREn}, 32'd1);
        chk("rd memWEn", {31'b0, memWEn}, 32'd0);
        chk("rd memAddr", memAddr, {25'b0, a});
        chk("rd rdValid early", {31'b0, rdValid}, 32'd0);
        @(negedge clk);
        rdReq = 1'b0;
        @(posedge clk); #1;
        chk("rd rdValid", {31'b0, rdValid}, 32'd1);
        chk("rd rdData", rdData, exp);
        chk("rd memREn resp", {31'b0, memREn}, 32'd0);
        @(posedge clk); #1;
        chk_quiet("rd-after");
        chk("rd rdData held", rdData, exp);
    endtask

    initial begin
        logic [31:0] exp;
        bit exp_w [10] = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        bit exp_r [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
        bit exp_v [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};

        vecs[0] = '{1'b1, 7'd5,   32'h11223344, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 7'd5,   32'h0,        32'h44332211, 32'h11223344};
        vecs[2] = '{1'b1, 7'd127, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 7'd127, 32'h0,        32'hEFBEADDE, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 7'd0,   32'hA5A50001, 32'h0,        32'h0};
        vecs[5] = '{1'b0, 7'd0,   32'h0,        32'h0100A5A5, 32'hA5A50001};
        vecs[6] = '{1'b1, 7'd5,   32'hCAFEF00D, 32'h0,        32'h0};
        vecs[7] = '{1'b0, 7'd5,   32'h0,        32'h0DF0FECA, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 7'd127, 32'h0,        32'hEFBEADDE, 32'hDEADBEEF};

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        rst = 1'b1; wrReq = 1'b0; rdReq = 1'b0;
        wrAddr = '0; rdAddr = '0; wrData = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        chk("reset rdData", rdData, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk_quiet("idle");
        end

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
            else begin
`ifdef RES_ARB_UNSWAP_EN
                exp = vecs[i].exp_unswap;
`else
                exp = vecs[i].exp_raw;
`endif
                do_read(vecs[i].addr, exp);
            end
        end

        // Both requesters raised together right after reset: W first, then strict alternation.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wrReq = 1'b1; rdReq = 1'b1; wrAddr = 7'd9; rdAddr = 7'd9; wrData = 32'h01020304;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("tie wrGnt c%0d", k + 1), {31'b0, wrGnt}, {31'b0, exp_w[k]});
            chk($sformatf("tie memREn c%0d", k + 1), {31'b0, memREn}, {31'b0, exp_r[k]});
            chk($sformatf("tie rdValid c%0d", k + 1), {31'b0, rdValid}, {31'b0, exp_v[k]});
        end
        @(negedge clk); wrReq = 1'b0; rdReq = 1'b0;
        repeat (4) @(posedge clk);

        // Reset landing during READ drops the response and clears rdData.
        @(negedge clk); rdReq = 1'b1; rdAddr = 7'd5;
        @(posedge clk); #1;
        chk("rstrd memREn", {31'b0, memREn}, 32'd1);
        @(negedge clk); rdReq = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        chk("rstrd rdValid", {31'b0, rdValid}, 32'd0);
        chk("rstrd rdData", rdData, 32'd0);
        chk("rstrd memREn", {31'b0, memREn}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rstrd rdValid later", {31'b0, rdValid}, 32'd0);
        do_write(7'd3, 32'h55AA55AA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
